coeff_load_ctrl: RTL and testbench

//  Sequencer that loads the FIR tap coefficients into the datapath's serial coefficient chain.

---
 rtl/coeff_load_ctrl_if.sv | 21 ++
 rtl/coeff_load_ctrl.sv | 163 ++++++++++++++++
 tb/tb_coeff_load_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coeff_load_ctrl_if.sv
// Coefficient load handshake bundle: host offers a word, controller accepts.
// master = host side, slave = coeff_load_ctrl side.
interface coeff_load_if #(
  parameter int W = 32
);
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_coeffs;

  modport master (
    output load_valid,
    output load_coeffs,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_coeffs,
    output load_ready
  );
endinterface

// File: rtl/coeff_load_ctrl.sv
// Serial coefficient loader: latches one NTAPS*CW word, shifts it MSB-first
// onto shiftIn with non-overlapping two-phase shift clocks.
// Ports: ph1/reset_n (sync, active-low), lif (valid/ready/coeffs),
// abort in; shiftIn, shiftClk1, shiftClk2, busy, done, aborted out.
module coeff_load_ctrl #(
  parameter int NTAPS = 4,
  parameter int CW    = 8,
  parameter int DIV   = 2
) (
  input  logic         ph1,
  input  logic         reset_n,
  coeff_load_if.slave  lif,
  input  logic         abort,
  output logic         shiftIn,
  output logic         shiftClk1,
  output logic         shiftClk2,
  output logic         busy,
  output logic         done,
  output logic         aborted
);

  localparam int NW = NTAPS * CW;
  localparam int BW = $clog2(NW);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CLK1,
    S_GAP,
    S_CLK2,
    S_DONE,
    S_ABORT
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [BW-1:0]   r_bit;
  logic [BW-1:0]   w_bit_nxt;
  logic [BW-1:0]   w_idx;
  logic [DW-1:0]   r_div;
  logic [DW-1:0]   w_div_nxt;
  logic [NW-1:0]   r_shadow;
  logic            w_load;
  logic            w_seg_end;
  logic            w_act;

  logic r_ready;
  logic r_busy;
  logic r_sin;
  logic r_clk1;
  logic r_clk2;
  logic r_done;
  logic r_abt;

  logic w_ready;
  logic w_busy;
  logic w_sin;
  logic w_clk1;
  logic w_clk2;
  logic w_done;
  logic w_abt;

  always_comb begin
    w_nxt     = r_state;
    w_bit_nxt = r_bit;
    w_div_nxt = r_div;
    w_load    = 1'b0;
    w_seg_end = (r_div == DW'(DIV - 1));
    w_act     = (r_state == S_SETUP) ||
                (r_state == S_CLK1)  ||
                (r_state == S_GAP)   ||
                (r_state == S_CLK2);
    w_idx     = BW'(NW - 1) - r_bit;

    if (w_act) begin
      w_div_nxt = w_seg_end ? '0 : r_div + 1'b1;
    end

    unique case (r_state)
      S_IDLE: begin
        // r_ready is cleared on the accept edge, so a word
        // is only taken once the host has seen ready high.
        if (lif.load_valid && r_ready) begin
          w_load    = 1'b1;
          w_nxt     = S_SETUP;
          w_bit_nxt = '0;
          w_div_nxt = '0;
        end
      end
      S_SETUP: if (w_seg_end) w_nxt = S_CLK1;
      S_CLK1:  if (w_seg_end) w_nxt = S_GAP;
      S_GAP:   if (w_seg_end) w_nxt = S_CLK2;
      S_CLK2: begin
        if (w_seg_end) begin
          if (r_bit == BW'(NW - 1)) begin
            w_nxt = S_DONE;
          end else begin
            w_nxt     = S_SETUP;
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      S_DONE:  w_nxt = S_IDLE;
      S_ABORT: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase

    if (w_act && abort) begin
      w_nxt     = S_ABORT;
      w_div_nxt = '0;
    end

    // Outputs are decoded from the current state and
    // registered, so they trail the state by one cycle.
    w_ready = (r_state == S_IDLE) && !w_load;
    w_busy  = w_act || (r_state == S_DONE);
    w_sin   = w_act && r_shadow[w_idx];
    w_clk1  = (r_state == S_CLK1);
    w_clk2  = (r_state == S_CLK2);
    w_done  = (r_state == S_DONE);
    w_abt   = (r_state == S_ABORT);
  end

  always_ff @(posedge ph1) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_bit    <= '0;
      r_div    <= '0;
      r_shadow <= '0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_sin    <= 1'b0;
      r_clk1   <= 1'b0;
      r_clk2   <= 1'b0;
      r_done   <= 1'b0;
      r_abt    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_bit   <= w_bit_nxt;
      r_div   <= w_div_nxt;
      if (w_load) begin
        r_shadow <= lif.load_coeffs;
      end
      r_ready <= w_ready;
      r_busy  <= w_busy;
      r_sin   <= w_sin;
      r_clk1  <= w_clk1;
      r_clk2  <= w_clk2;
      r_done  <= w_done;
      r_abt   <= w_abt;
    end
  end

  assign lif.load_ready = r_ready;
  assign busy           = r_busy;
  assign shiftIn        = r_sin;
  assign shiftClk1      = r_clk1;
  assign shiftClk2      = r_clk2;
  assign done           = r_done;
  assign aborted        = r_abt;

endmodule

// File: tb/tb_coeff_load_ctrl.sv
// Self-checking bench for coeff_load_ctrl: behavioural output model,
// per-cycle compare, serial-capture and latency checks.
module tb_coeff_load_ctrl;

  localparam int NT  = 4;
  localparam int CW  = 8;
  localparam int DIV = 2;
  localparam int NW  = NT * CW;

  logic ph1     = 1'b0;
  logic reset_n = 1'b0;
  logic abort   = 1'b0;
  logic shiftIn;
  logic shiftClk1;
  logic shiftClk2;
  logic busy;
  logic done;
  logic aborted;

  coeff_load_if #(.W(NW)) lif ();

  coeff_load_ctrl #(.NTAPS(NT), .CW(CW), .DIV(DIV)) dut (
    .ph1       (ph1),
    .reset_n   (reset_n),
    .lif       (lif),
    .abort     (abort),
    .shiftIn   (shiftIn),
    .shiftClk1 (shiftClk1),
    .shiftClk2 (shiftClk2),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  always #5 ph1 = ~ph1;

  typedef struct packed {
    logic rdy;
    logic bsy;
    logic sin;
    logic c1;
    logic c2;
    logic dn;
    logic ab;
  } o_t;

  int total = 0;
  int bad   = 0;

  o_t          e = '0;
  int          k = -1;
  int          abm = 0;
  logic [NW-1:0] word = '0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          acc_n = 0;
  bit          mvalid = 0;

  // Expected outputs m edges after the accepting edge.
  function automatic o_t pat(int m, logic [NW-1:0] w);
    o_t r;
    int j;
    int b;
    int ph;
    r = '0;
    if (m <= NW * 4 * DIV) begin
      j     = m - 1;
      b     = j / (4 * DIV);
      ph    = (j / DIV) % 4;
      r.bsy = 1'b1;
      r.sin = w[NW-1-b];
      r.c1  = (ph == 1);
      r.c2  = (ph == 3);
    end else if (m == NW * 4 * DIV + 1) begin
      r.bsy = 1'b1;
      r.dn  = 1'b1;
    end else begin
      r.rdy = 1'b1;
    end
    return r;
  endfunction

  always @(posedge ph1) begin
    logic prdy;
    prdy = e.rdy;
    cyc++;
    if (!reset_n) begin
      e     = '0;
      e.rdy = 1'b1;
      k     = -1;
      abm   = 0;
    end else if (abm == 1) begin
      e    = '0;
      e.ab = 1'b1;
      abm  = 2;
    end else if (abm == 2) begin
      e     = '0;
      e.rdy = 1'b1;
      abm   = 0;
    end else if (k >= 0) begin
      k++;
      e = pat(k, word);
      if (abort && k <= NW * 4 * DIV) begin
        abm = 1;
        k   = -1;
      end else if (k >= NW * 4 * DIV + 2) begin
        k = -1;
      end
    end else if (prdy && lif.load_valid) begin
      word    = lif.load_coeffs;
      k       = 0;
      e       = '0;
      acc_cyc = cyc;
      acc_n++;
    end else begin
      e     = '0;
      e.rdy = 1'b1;
    end
    mvalid = 1;
  end

  logic [NW-1:0] cap = '0;
  int   ncap = 0;
  int   seen_acc = 0;
  int   done_cyc = 0;
  int   dn_seen = 0;
  int   ab_seen = 0;
  int   ab_clk = 0;
  logic pc1 = 1'b0;
  logic pc2 = 1'b0;
  int   lowrun = 0;
  int   last_clk = 0;
  int   hirun = 0;

  always @(negedge ph1) begin
    o_t a;
    if (mvalid) begin
      a = {lif.load_ready, busy, shiftIn, shiftClk1,
           shiftClk2, done, aborted};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs cyc=%0d got=%b want=%b (rdy,bsy,sin,c1,c2,dn,ab)",
                 cyc, a, e);
      end
      total++;
      if (shiftClk1 && shiftClk2) begin
        bad++;
        $display("FAIL overlap cyc=%0d got both clocks 1 want not both", cyc);
      end
      if (acc_n != seen_acc) begin
        seen_acc = acc_n;
        ncap     = 0;
        cap      = '0;
      end
      if (shiftClk1 && !pc1) begin
        cap = {cap[NW-2:0], shiftIn};
        ncap++;
      end
      if (shiftClk1) hirun++;
      if (!shiftClk1 && pc1) begin
        if (e.bsy) begin
          total++;
          if (hirun != DIV) begin
            bad++;
            $display("FAIL clk1_width cyc=%0d got %0d want %0d", cyc, hirun, DIV);
          end
        end
        hirun = 0;
      end
      if (shiftClk1 != pc1 || shiftClk2 != pc2) begin
        if (shiftClk1 != pc1) begin
          if (last_clk == 2) begin
            total++;
            if (lowrun < DIV) begin
              bad++;
              $display("FAIL gap cyc=%0d got %0d low want >=%0d", cyc, lowrun, DIV);
            end
          end
          last_clk = 1;
        end else begin
          if (last_clk == 1) begin
            total++;
            if (lowrun < DIV) begin
              bad++;
              $display("FAIL gap cyc=%0d got %0d low want >=%0d", cyc, lowrun, DIV);
            end
          end
          last_clk = 2;
        end
        lowrun = 0;
      end
      if (!shiftClk1 && !shiftClk2) lowrun++;
      if (done) begin
        done_cyc = cyc;
        dn_seen++;
      end
      if (aborted) begin
        ab_seen++;
        if (shiftClk1 || shiftClk2) ab_clk++;
      end
      pc1 = shiftClk1;
      pc2 = shiftClk2;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [NW-1:0] w);
    int n0;
    bit ok;
    n0 = acc_n;
    ok = 0;
    @(negedge ph1);
    lif.load_valid  = 1'b1;
    lif.load_coeffs = w;
    for (int i = 0; i < 700; i++) begin
      @(negedge ph1);
      if (acc_n != n0) begin
        ok = 1;
        break;
      end
    end
    lif.load_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge ph1);
      if (k < 0 && abm == 0 && e.rdy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    logic [NW-1:0] w;
    logic [NW-1:0] w2;
    int d0;
    int a0;
    int e1;
    int at;
    bit ok;
    lif.load_valid  = 1'b0;
    lif.load_coeffs = '0;

    // reset
    repeat (3) @(negedge ph1);
    chk("rst_ready", lif.load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_clks", {shiftIn, shiftClk1, shiftClk2}, 0);
    chk("rst_pulses", {done, aborted}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge ph1);

    // known word
    load(32'h0403_0201);
    wait_idle();
    chk("t2_bits", cap, 32'h0403_0201);
    chk("t2_npulse", ncap, 32);
    chk("t2_latency", done_cyc - acc_cyc, 257);

    // valid with garbage while busy
    w = $urandom;
    load(w);
    lif.load_valid  = 1'b1;
    lif.load_coeffs = 32'hFFFF_FFFF;
    repeat (100) @(negedge ph1);
    lif.load_valid = 1'b0;
    wait_idle();
    chk("t4_bits", cap, w);

    // abort after 10 bits
    d0 = dn_seen;
    a0 = ab_seen;
    load($urandom);
    repeat (10 * 4 * DIV + 3) @(negedge ph1);
    abort = 1'b1;
    @(negedge ph1);
    abort = 1'b0;
    wait_idle();
    chk("t5_aborted", ab_seen - a0, 1);
    chk("t5_nodone", dn_seen - d0, 0);
    chk("t5_clklow", ab_clk, 0);
    load(32'hA5A5_A5A5);
    wait_idle();
    chk("t5_bits", cap, 32'hA5A5_A5A5);

    // reset during CLK1
    load($urandom);
    repeat (20) @(negedge ph1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (shiftClk1) begin
        ok = 1;
        break;
      end
      @(negedge ph1);
    end
    chk("t6_found_clk1", ok, 1);
    reset_n = 1'b0;
    @(negedge ph1);
    reset_n = 1'b1;
    chk("t6_clk1_low", shiftClk1, 0);
    chk("t6_ready", lif.load_ready, 1);
    chk("t6_busy", busy, 0);

    // abort and reset together
    a0 = ab_seen;
    load($urandom);
    repeat (30) @(negedge ph1);
    abort   = 1'b1;
    reset_n = 1'b0;
    @(negedge ph1);
    abort   = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge ph1);
    chk("t7_no_abort", ab_seen - a0, 0);

    // back-to-back with valid held high
    w  = $urandom;
    w2 = $urandom;
    load(w);
    e1 = acc_cyc;
    lif.load_valid  = 1'b1;
    lif.load_coeffs = w2;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge ph1);
      if (acc_cyc != e1) begin
        ok = 1;
        break;
      end
    end
    lif.load_valid = 1'b0;
    chk("t6_b2b_found", ok, 1);
    chk("t6_b2b_gap", acc_cyc - e1, 259);
    wait_idle();
    chk("t6_b2b_bits", cap, w2);

    // randomized loads, aborts and stray valids
    for (int it = 0; it < 14; it++) begin
      repeat ($urandom_range(0, 5)) @(negedge ph1);
      w = $urandom;
      load(w);
      at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 262) : 0;
      for (int c = 1; c <= 270; c++) begin
        @(negedge ph1);
        abort           = (c == at);
        lif.load_valid  = ($urandom_range(0, 3) == 0);
        lif.load_coeffs = $urandom;
      end
      abort          = 1'b0;
      lif.load_valid = 1'b0;
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
